// File: rtl/program_loader_pkg.sv
// Shared constants, state encoding and address helper for the program memory loader.
package program_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned ADDR_SHIFT     = 2;
    localparam int unsigned CNT_W          = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

    // Word index to byte address, matching the fetch path's Address[31:2] decode.
    function automatic logic [WORD_W-1:0] word_to_byte_addr(input logic [WORD_W-1:0] idx);
        return idx << ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// Byte stream input and instruction-memory write port of the loader.
interface program_memory_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    import program_loader_pkg::*;

    logic [BYTE_W-1:0]     RxData;
    logic                  RxValid;
    logic                  RxReady;
    logic                  MemWriteEnable;
    logic [DATA_WIDTH-1:0] MemAddress;
    logic [DATA_WIDTH-1:0] MemWriteData;

    modport master (
        input  RxData, RxValid,
        output RxReady, MemWriteEnable, MemAddress, MemWriteData
    );

    modport slave (
        output RxData, RxValid,
        input  RxReady, MemWriteEnable, MemAddress, MemWriteData
    );

endinterface

// File: rtl/byte_word_assembler.sv
// Shifts accepted bytes into a big-endian 32-bit word; flags the byte that completes a word.
module byte_word_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] word_next_c,
    output logic              word_valid_c
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign word_next_c  = {shift_q[WORD_W-BYTE_W-1:0], byte_data};
    assign word_valid_c = byte_valid && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word         = shift_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = word_next_c;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/program_memory_loader.sv
// Loads a length-prefixed byte image into instruction memory, holding the CPU until complete.
module program_memory_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Start,
    program_memory_loader_if.master bus,
    output logic                    CpuHold,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error
);

    // One extra bit so a full-depth image count is representable.
    localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  word_index_q, word_index_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic              rx_ready_q, rx_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer_c;
    logic              asm_clear_c;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_next_c;
    logic [WORD_W-1:0] shift_word;

    assign xfer_c = bus.RxValid && rx_ready_q;

    byte_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear        (asm_clear_c),
        .byte_valid   (xfer_c),
        .byte_data    (bus.RxData),
        .word         (shift_word),
        .word_next_c  (word_next_c),
        .word_valid_c (word_valid_c)
    );

    // Next state, counters, and output flags decoded from the next state.
    always_comb begin
        state_d      = state_q;
        word_index_d = word_index_q;
        n_d          = n_q;
        asm_clear_c  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (Start) begin
                    state_d      = ST_HEADER;
                    word_index_d = '0;
                    asm_clear_c  = 1'b1;
                end
            end
            ST_HEADER: begin
                if (word_valid_c) begin
                    if ((word_next_c == '0) || (word_next_c > WORD_W'(MEMORY_DEPTH))) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d     = IDX_W'(word_next_c);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid_c) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_index_d = word_index_q + IDX_W'(1);
                state_d      = (word_index_d == n_q) ? ST_DONE : ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rx_ready_d = (state_d == ST_HEADER) || (state_d == ST_LOAD);
        mem_we_d   = (state_d == ST_WRITE);
        busy_d     = rx_ready_d || mem_we_d;
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERROR);
        cpu_hold_d = busy_d || error_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_index_q <= '0;
            n_q          <= '0;
            rx_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_index_q <= word_index_d;
            n_q          <= n_d;
            rx_ready_q   <= rx_ready_d;
            mem_we_q     <= mem_we_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.RxReady        = rx_ready_q;
    assign bus.MemWriteEnable = mem_we_q;
    assign bus.MemAddress     = DATA_WIDTH'(word_to_byte_addr(WORD_W'(word_index_q)));
    assign bus.MemWriteData   = DATA_WIDTH'(shift_word);
    assign CpuHold            = cpu_hold_q;
    assign Busy               = busy_q;
    assign Done               = done_q;
    assign Error              = error_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench: random images checked against an expected list of (address, word) writes.
module tb_program_memory_loader;

    logic clk = 1'b0;
    logic reset;
    logic Start;
    logic CpuHold, Busy, Done, Error;

    int checks = 0;
    int errors = 0;

    logic [31:0] img_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    program_memory_loader_if #(.DATA_WIDTH(32)) bus ();

    program_memory_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .bus     (bus),
        .CpuHold (CpuHold),
        .Busy    (Busy),
        .Done    (Done),
        .Error   (Error)
    );

    always #5 clk = ~clk;

    // Record every memory write strobe seen by the memory.
    always @(negedge clk) begin
        if (bus.MemWriteEnable === 1'b1) begin
            wr_addr_q.push_back(bus.MemAddress);
            wr_data_q.push_back(bus.MemWriteData);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset       = 1'b1;
        Start       = 1'b0;
        bus.RxValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.RxValid = 1'b0;
        Start       = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Offer one byte until accepted; returns right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            bus.RxData  = b;
            bus.RxValid = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            if (bus.RxValid && bus.RxReady) ok = 1'b1;
            @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, output bit ok);
        ok = 1'b1;
        for (int i = 3; i >= 0 && ok; i--) begin
            send_byte(w[8*i +: 8], gaps, ok);
        end
    endtask

    // Start, send header + img_q, then compare writes and final status with the expected image.
    task automatic run_image(input logic [31:0] hdr, input bit gaps, input bit mid_start, input string tag);
        bit ok;
        bit legal;
        int exp_n;
        wr_addr_q.delete();
        wr_data_q.delete();
        legal = (hdr != 0) && (hdr <= 32);
        pulse_start();
        checks++;
        if (bus.RxReady !== 1'b1 || Busy !== 1'b1 || CpuHold !== 1'b1 || Done !== 1'b0 || Error !== 1'b0) begin
            errors++;
            $display("FAIL %s start: rdy=%b busy=%b hold=%b done=%b err=%b want 1 1 1 0 0",
                     tag, bus.RxReady, Busy, CpuHold, Done, Error);
        end
        send_word(hdr, gaps, ok);
        if (ok && legal && mid_start) begin
            pulse_start();
            checks++;
            if (Busy !== 1'b1 || bus.RxReady !== 1'b1) begin
                errors++;
                $display("FAIL %s start_in_load: busy=%b rdy=%b want 1 1", tag, Busy, bus.RxReady);
            end
        end
        if (ok && legal) begin
            foreach (img_q[i]) begin
                if (ok) send_word(img_q[i], gaps, ok);
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: byte not accepted got 0 want 1", tag);
        end
        repeat (3) @(negedge clk);
        bus.RxValid = 1'b0;
        exp_n = legal ? img_q.size() : 0;
        checks++;
        if (wr_addr_q.size() != exp_n) begin
            errors++;
            $display("FAIL %s write_count got %0d want %0d", tag, wr_addr_q.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== img_q[i]) begin
                errors++;
                $display("FAIL %s write[%0d] got %h@%h want %h@%h",
                         tag, i, wr_data_q[i], wr_addr_q[i], img_q[i], 32'(i * 4));
            end
        end
        checks++;
        if (legal && (Done !== 1'b1 || CpuHold !== 1'b0 || Busy !== 1'b0 || Error !== 1'b0 || bus.RxReady !== 1'b0)) begin
            errors++;
            $display("FAIL %s done_status: done=%b hold=%b busy=%b err=%b rdy=%b want 1 0 0 0 0",
                     tag, Done, CpuHold, Busy, Error, bus.RxReady);
        end else if (!legal && (Error !== 1'b1 || CpuHold !== 1'b1 || Done !== 1'b0 || Busy !== 1'b0 || bus.RxReady !== 1'b0)) begin
            errors++;
            $display("FAIL %s error_status: err=%b hold=%b done=%b busy=%b rdy=%b want 1 1 0 0 0",
                     tag, Error, CpuHold, Done, Busy, bus.RxReady);
        end
    endtask

    task automatic fill_random(input int n);
        img_q.delete();
        for (int i = 0; i < n; i++) img_q.push_back($urandom);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        Start       = 1'b0;
        bus.RxValid = 1'b0;
        bus.RxData  = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.RxReady !== 1'b0 || bus.MemWriteEnable !== 1'b0 || bus.MemAddress !== 32'h0 ||
            bus.MemWriteData !== 32'h0 || CpuHold !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b want all 0",
                     bus.RxReady, bus.MemWriteEnable, bus.MemAddress, bus.MemWriteData, CpuHold, Busy, Done, Error);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        Start = 1'b1;
        checks++;
        if (bus.RxReady !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got %b want 0", bus.RxReady);
        end
        @(negedge clk);
        Start = 1'b0;
        checks++;
        if (bus.RxReady !== 1'b1 || CpuHold !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: rdy=%b hold=%b busy=%b want 1 1 1", bus.RxReady, CpuHold, Busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        bit all_ok;
        apply_reset();
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_word(32'h0000_0002, 1'b0, ok);
        all_ok = ok;
        send_word(32'h2008_0005, 1'b0, ok);
        all_ok &= ok;
        @(negedge clk);
        bus.RxValid = 1'b0;
        checks++;
        if (bus.MemWriteEnable !== 1'b1 || bus.MemAddress !== 32'h0 || bus.MemWriteData !== 32'h2008_0005 || bus.RxReady !== 1'b0) begin
            errors++;
            $display("FAIL basic_w0: we=%b addr=%h data=%h rdy=%b want 1 00000000 20080005 0",
                     bus.MemWriteEnable, bus.MemAddress, bus.MemWriteData, bus.RxReady);
        end
        @(negedge clk);
        checks++;
        if (bus.MemWriteEnable !== 1'b0 || bus.RxReady !== 1'b1) begin
            errors++;
            $display("FAIL basic_after_w0: we=%b rdy=%b want 0 1", bus.MemWriteEnable, bus.RxReady);
        end
        send_word(32'h0109_5020, 1'b0, ok);
        all_ok &= ok;
        @(negedge clk);
        bus.RxValid = 1'b0;
        checks++;
        if (bus.MemWriteEnable !== 1'b1 || bus.MemAddress !== 32'h4 || bus.MemWriteData !== 32'h0109_5020) begin
            errors++;
            $display("FAIL basic_w1: we=%b addr=%h data=%h want 1 00000004 01095020",
                     bus.MemWriteEnable, bus.MemAddress, bus.MemWriteData);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b1 || CpuHold !== 1'b0 || Busy !== 1'b0 || bus.RxReady !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b hold=%b busy=%b rdy=%b want 1 0 0 0", Done, CpuHold, Busy, bus.RxReady);
        end
        @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 2 || !all_ok) begin
            errors++;
            $display("FAIL basic_strobes got %0d (accepted=%b) want 2 (accepted=1)", wr_addr_q.size(), all_ok);
        end
    endtask

    task automatic test_bad_header();
        apply_reset();
        img_q.delete();
        run_image(32'h0000_0000, 1'b0, 1'b0, "hdr_zero");
        run_image(32'h0000_0021, 1'b0, 1'b0, "hdr_33");
        fill_random(32);
        run_image(32'h0000_0020, 1'b0, 1'b0, "hdr_full");
    endtask

    task automatic test_gaps();
        int n;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 10);
            fill_random(n);
            run_image(32'(n), 1'b1, 1'b0, "gaps");
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        fill_random(3);
        run_image(32'd3, 1'b0, 1'b1, "start_in_load");
        fill_random(2);
        run_image(32'd2, 1'b0, 1'b0, "restart_from_done");
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        pulse_start();
        send_word(32'h0000_0002, 1'b0, ok);
        if (ok) send_byte(8'hAA, 1'b0, ok);
        if (ok) send_byte(8'hBB, 1'b0, ok);
        @(negedge clk);
        reset       = 1'b1;
        bus.RxValid = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || bus.RxReady !== 1'b0 || bus.MemWriteData !== 32'h0 || bus.MemAddress !== 32'h0 ||
            CpuHold !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ok=%b rdy=%b data=%h addr=%h hold=%b busy=%b done=%b err=%b want 1 0 0 0 0 0 0 0",
                     ok, bus.RxReady, bus.MemWriteData, bus.MemAddress, CpuHold, Busy, Done, Error);
        end
        reset = 1'b0;
        fill_random(2);
        run_image(32'd2, 1'b0, 1'b0, "after_mid_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
